// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the fp16 arithmetic leaf blocks.
package fp16_pkg;

    localparam int          EXP_BIAS = 15;
    localparam int          EXP_MAX  = 31;
    localparam logic [15:0] QNAN     = 16'h7E00;
    localparam logic [15:0] PINF     = 16'h7C00;

    // Bit positions inside the {invalid, overflow, underflow} flag vector
    localparam int UF  = 0;
    localparam int OF  = 1;
    localparam int INV = 2;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

endpackage

// File: rtl/fp16_lzc.sv
// 14-bit leading-zero counter; an all-zero input reports 14.
module fp16_lzc (
    input  logic [13:0] data,
    output logic [3:0]  count
);

    logic found_s;

    // Scan from the MSB down and latch the position of the first set bit
    always_comb begin
        found_s = 1'b0;
        count   = 4'd14;
        for (int i = 13; i >= 0; i--) begin
            if (!found_s && data[i]) begin
                found_s = 1'b1;
                count   = 4'(13 - i);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fp16_subtract.sv
// Four-stage pipelined binary16 subtractor (A - B), one operation per clock.
// Special operands (NaN, Inf, zero) are resolved in the first stage and ride
// alongside the finite datapath; the last stage picks between them.
module fp16_subtract
    import fp16_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_a_tvalid,
    input  logic [15:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    input  logic [15:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    output logic [15:0] m_axis_result_tdata,
    output logic [2:0]  m_axis_result_tuser
);

    // ---------------- S1: unpack, classify, swap ----------------
    fp16_t       a_s, b_s, x_s, y_s;
    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic        spec_s;
    logic [15:0] spec_data_s;
    logic [2:0]  spec_user_s;
    logic        issue_s;

    logic        v1_r, spec1_r, sign1_r, sub1_r;
    logic [15:0] spec_data1_r;
    logic [2:0]  spec_user1_r;
    logic [4:0]  exp1_r, diff1_r;
    logic [10:0] sigx1_r, sigy1_r;

    assign issue_s = s_axis_a_tvalid & s_axis_b_tvalid;

    // Negate B, classify both operands and resolve every non-finite/zero case
    always_comb begin
        a_s      = fp16_t'(s_axis_a_tdata);
        b_s      = fp16_t'(s_axis_b_tdata);
        b_s.sign = ~b_s.sign;
        a_nan_s  = (a_s.exp == 5'(EXP_MAX)) && (a_s.frac != 10'd0);
        b_nan_s  = (b_s.exp == 5'(EXP_MAX)) && (b_s.frac != 10'd0);
        a_inf_s  = (a_s.exp == 5'(EXP_MAX)) && (a_s.frac == 10'd0);
        b_inf_s  = (b_s.exp == 5'(EXP_MAX)) && (b_s.frac == 10'd0);
        a_zero_s = (a_s.exp == 5'd0);
        b_zero_s = (b_s.exp == 5'd0);
        spec_s      = 1'b1;
        spec_data_s = 16'h0000;
        spec_user_s = 3'b000;
        if (a_nan_s || b_nan_s) begin
            spec_data_s      = QNAN;
            spec_user_s[INV] = (a_nan_s & ~a_s.frac[9]) | (b_nan_s & ~b_s.frac[9]);
        end else if (a_inf_s && b_inf_s) begin
            if (a_s.sign != b_s.sign) begin
                spec_data_s      = QNAN;
                spec_user_s[INV] = 1'b1;
            end else begin
                spec_data_s = PINF | {a_s.sign, 15'h0000};
            end
        end else if (a_inf_s) begin
            spec_data_s = a_s;
        end else if (b_inf_s) begin
            spec_data_s = b_s;
        end else if (a_zero_s && b_zero_s) begin
            // Subnormals count as zero; the sum of two zeros is -0 only if both are -0
            spec_data_s = {a_s.sign & b_s.sign, 15'h0000};
        end else if (b_zero_s) begin
            spec_data_s = a_s;
        end else if (a_zero_s) begin
            spec_data_s = b_s;
        end else begin
            spec_s = 1'b0;
        end
        // Larger magnitude goes first so the significand difference is never negative
        if (a_s[14:0] >= b_s[14:0]) begin
            x_s = a_s;
            y_s = b_s;
        end else begin
            x_s = b_s;
            y_s = a_s;
        end
    end

    // Stage-1 register: classification result and swapped operands
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1_r         <= 1'b0;
            spec1_r      <= 1'b0;
            spec_data1_r <= 16'h0000;
            spec_user1_r <= 3'b000;
            sign1_r      <= 1'b0;
            sub1_r       <= 1'b0;
            exp1_r       <= 5'd0;
            diff1_r      <= 5'd0;
            sigx1_r      <= 11'd0;
            sigy1_r      <= 11'd0;
        end else begin
            v1_r <= issue_s;
            if (issue_s) begin
                spec1_r      <= spec_s;
                spec_data1_r <= spec_data_s;
                spec_user1_r <= spec_user_s;
                sign1_r      <= x_s.sign;
                sub1_r       <= x_s.sign ^ y_s.sign;
                exp1_r       <= x_s.exp;
                diff1_r      <= x_s.exp - y_s.exp;
                sigx1_r      <= {1'b1, x_s.frac};
                sigy1_r      <= {1'b1, y_s.frac};
            end
        end
    end

    // ---------------- S2: align, add/sub ----------------
    logic [13:0] xe_s, ye_s, ye_al_s, mask_s;
    logic [14:0] sum_s;
    logic        sticky_s;

    logic        v2_r, spec2_r, sign2_r;
    logic [15:0] spec_data2_r;
    logic [2:0]  spec_user2_r;
    logic [4:0]  exp2_r;
    logic [14:0] sum2_r;

    // Shift the smaller significand right, folding lost bits into the sticky LSB
    always_comb begin
        xe_s   = {sigx1_r, 3'b000};
        ye_s   = {sigy1_r, 3'b000};
        mask_s = 14'd0;
        if (diff1_r >= 5'd14) begin
            sticky_s = 1'b1;
            ye_al_s  = 14'd1;
        end else begin
            mask_s   = (14'd1 << diff1_r) - 14'd1;
            sticky_s = |(ye_s & mask_s);
            ye_al_s  = (ye_s >> diff1_r) | {13'd0, sticky_s};
        end
        if (sub1_r) begin
            sum_s = {1'b0, xe_s} - {1'b0, ye_al_s};
        end else begin
            sum_s = {1'b0, xe_s} + {1'b0, ye_al_s};
        end
    end

    // Stage-2 register: raw significand sum
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v2_r         <= 1'b0;
            spec2_r      <= 1'b0;
            spec_data2_r <= 16'h0000;
            spec_user2_r <= 3'b000;
            sign2_r      <= 1'b0;
            exp2_r       <= 5'd0;
            sum2_r       <= 15'd0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                spec2_r      <= spec1_r;
                spec_data2_r <= spec_data1_r;
                spec_user2_r <= spec_user1_r;
                sign2_r      <= sign1_r;
                exp2_r       <= exp1_r;
                sum2_r       <= sum_s;
            end
        end
    end

    // ---------------- S3: normalise, round ----------------
    logic [3:0]        lz_s;
    logic [13:0]       norm_s;
    logic [11:0]       rsig_s;
    logic              round_up_s;
    logic signed [6:0] exp_n_s;
    logic [9:0]        frac_n_s;

    logic              v3_r, spec3_r, sign3_r, zero3_r;
    logic [15:0]       spec_data3_r;
    logic [2:0]        spec_user3_r;
    logic signed [6:0] exp3_r;
    logic [9:0]        frac3_r;

    fp16_lzc u_lzc (
        .data  (sum2_r[13:0]),
        .count (lz_s)
    );

    // Bring the leading one to bit 13, then round to nearest even on G/R/S
    always_comb begin
        if (sum2_r[14]) begin
            norm_s  = sum2_r[14:1] | {13'd0, sum2_r[0]};
            exp_n_s = 7'({2'b00, exp2_r}) + 7'sd1;
        end else begin
            norm_s  = sum2_r[13:0] << lz_s;
            exp_n_s = 7'({2'b00, exp2_r}) - 7'({3'b000, lz_s});
        end
        round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        rsig_s     = {1'b0, norm_s[13:3]} + {11'd0, round_up_s};
        if (rsig_s[11]) begin
            frac_n_s = rsig_s[10:1];
            exp_n_s  = exp_n_s + 7'sd1;
        end else begin
            frac_n_s = rsig_s[9:0];
        end
    end

    // Stage-3 register: normalised, rounded fields
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v3_r         <= 1'b0;
            spec3_r      <= 1'b0;
            spec_data3_r <= 16'h0000;
            spec_user3_r <= 3'b000;
            sign3_r      <= 1'b0;
            zero3_r      <= 1'b0;
            exp3_r       <= 7'sd0;
            frac3_r      <= 10'd0;
        end else begin
            v3_r <= v2_r;
            if (v2_r) begin
                spec3_r      <= spec2_r;
                spec_data3_r <= spec_data2_r;
                spec_user3_r <= spec_user2_r;
                sign3_r      <= sign2_r;
                zero3_r      <= (sum2_r == 15'd0);
                exp3_r       <= exp_n_s;
                frac3_r      <= frac_n_s;
            end
        end
    end

    // ---------------- S4: pack, exception mux ----------------
    logic [15:0] res_data_s;
    logic [2:0]  res_user_s;

    // Select special result, exact cancellation, flush-to-zero, overflow or normal pack
    always_comb begin
        res_data_s = 16'h0000;
        res_user_s = 3'b000;
        if (spec3_r) begin
            res_data_s = spec_data3_r;
            res_user_s = spec_user3_r;
        end else if (zero3_r) begin
            res_data_s = 16'h0000;
        end else if (exp3_r < 7'sd1) begin
            res_data_s     = {sign3_r, 15'h0000};
            res_user_s[UF] = 1'b1;
        end else if (exp3_r > 7'sd30) begin
            res_data_s     = PINF | {sign3_r, 15'h0000};
            res_user_s[OF] = 1'b1;
        end else begin
            res_data_s = {sign3_r, exp3_r[4:0], frac3_r};
        end
    end

    // Output register: data/flags hold their last value between results
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= 16'h0000;
            m_axis_result_tuser  <= 3'b000;
        end else begin
            m_axis_result_tvalid <= v3_r;
            if (v3_r) begin
                m_axis_result_tdata <= res_data_s;
                m_axis_result_tuser <= res_user_s;
            end
        end
    end

endmodule

// File: tb/tb_fp16_subtract.sv
// Directed bench for fp16_subtract: vector table streamed through a scoreboard,
// plus latency, valid-gating and mid-flight reset sequences.
module tb_fp16_subtract;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        a_tvalid = 1'b0;
    logic [15:0] a_tdata = 16'h0000;
    logic        b_tvalid = 1'b0;
    logic [15:0] b_tdata = 16'h0000;
    logic        r_tvalid;
    logic [15:0] r_tdata;
    logic [2:0]  r_tuser;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  user;
    } vec_t;

    localparam int NV = 23;
    vec_t        tbl [NV];
    logic [18:0] exp_q [$];
    logic [18:0] mon_exp;
    int          checks = 0;
    int          failures = 0;
    int          out_cnt = 0;

    fp16_subtract dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_a_tvalid      (a_tvalid),
        .s_axis_a_tdata       (a_tdata),
        .s_axis_b_tvalid      (b_tvalid),
        .s_axis_b_tdata       (b_tdata),
        .m_axis_result_tvalid (r_tvalid),
        .m_axis_result_tdata  (r_tdata),
        .m_axis_result_tuser  (r_tuser)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard: every emitted result must match the oldest outstanding expectation
    always @(negedge aclk) begin
        if (aresetn && r_tvalid) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %h with nothing outstanding", {r_tuser, r_tdata});
            end else begin
                mon_exp = exp_q.pop_front();
                check("result {tuser,tdata}", {r_tuser, r_tdata}, mon_exp);
            end
        end
    end

    task automatic drive(input logic av, input logic bv, input logic [15:0] a, input logic [15:0] b);
        a_tvalid = av;
        b_tvalid = bv;
        a_tdata  = a;
        b_tdata  = b;
    endtask

    // Back-to-back issue of table entries; tvalid must be high exactly for
    // negedges 4..n+3 counted from the first drive (no gaps, latency 4)
    task automatic run_stream(input int first, input int n);
        for (int k = 0; k <= n + 4; k++) begin
            @(negedge aclk);
            check($sformatf("stream%0d_valid_k%0d", first, k), {18'd0, r_tvalid},
                  {18'd0, (k >= 4 && k < n + 4) ? 1'b1 : 1'b0});
            if (k < n) begin
                drive(1'b1, 1'b1, tbl[first + k].a, tbl[first + k].b);
                exp_q.push_back({tbl[first + k].user, tbl[first + k].res});
            end else begin
                drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            end
        end
    endtask

    initial begin
        int dual;
        int base;
        logic [7:0] av_pat;
        logic [7:0] bv_pat;

        tbl[0]  = '{16'h3CF0, 16'h4D56, 16'hCD07, 3'b000};
        tbl[1]  = '{16'h7935, 16'h7502, 16'h7568, 3'b000};
        tbl[2]  = '{16'h6400, 16'hB800, 16'h6400, 3'b000};
        tbl[3]  = '{16'h6401, 16'hB800, 16'h6402, 3'b000};
        tbl[4]  = '{16'h3C00, 16'h1000, 16'h3BFF, 3'b000};
        tbl[5]  = '{16'h3C00, 16'h3C00, 16'h0000, 3'b000};
        tbl[6]  = '{16'hBC00, 16'hBC00, 16'h0000, 3'b000};
        tbl[7]  = '{16'h7BFF, 16'hFBFF, 16'h7C00, 3'b010};
        tbl[8]  = '{16'h7C00, 16'h7C00, 16'h7E00, 3'b100};
        tbl[9]  = '{16'hFC00, 16'hFC00, 16'h7E00, 3'b100};
        tbl[10] = '{16'h7C00, 16'hFC00, 16'h7C00, 3'b000};
        tbl[11] = '{16'h7C00, 16'h3C00, 16'h7C00, 3'b000};
        tbl[12] = '{16'h3C00, 16'h7C00, 16'hFC00, 3'b000};
        tbl[13] = '{16'h7D00, 16'h3C00, 16'h7E00, 3'b100};
        tbl[14] = '{16'h7E00, 16'h3C00, 16'h7E00, 3'b000};
        tbl[15] = '{16'h0400, 16'h0000, 16'h0400, 3'b000};
        tbl[16] = '{16'h0401, 16'h0400, 16'h0000, 3'b001};
        tbl[17] = '{16'h8000, 16'h0000, 16'h8000, 3'b000};
        tbl[18] = '{16'h0000, 16'h8000, 16'h0000, 3'b000};
        tbl[19] = '{16'h0001, 16'h3C00, 16'hBC00, 3'b000};
        tbl[20] = '{16'h3C00, 16'hBC00, 16'h4000, 3'b000};
        tbl[21] = '{16'hFBFF, 16'h7BFF, 16'hFC00, 3'b010};
        tbl[22] = '{16'h3C00, 16'hFD00, 16'h7E00, 3'b100};

        // Reset state
        repeat (3) @(negedge aclk);
        check("reset_tvalid", {18'd0, r_tvalid}, 19'd0);
        check("reset_tdata", {3'd0, r_tdata}, 19'd0);
        check("reset_tuser", {16'd0, r_tuser}, 19'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Single operation: latency check, then the rest of the table streamed
        run_stream(0, 1);
        run_stream(1, NV - 1);

        // Output holds the last result once tvalid drops
        check("hold_tvalid", {18'd0, r_tvalid}, 19'd0);
        check("hold_data", {r_tuser, r_tdata}, {tbl[NV - 1].user, tbl[NV - 1].res});

        // Lone A valid for three cycles: nothing may come out
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            if (k < 3) drive(1'b1, 1'b0, 16'h3C00, 16'h3C00);
            else       drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            check($sformatf("lone_a_valid_k%0d", k), {18'd0, r_tvalid}, 19'd0);
        end

        // Mixed valid patterns: output count equals the dual-valid count
        av_pat = 8'b1011_0110;
        bv_pat = 8'b1101_0011;
        dual   = 0;
        base   = out_cnt;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            drive(av_pat[k], bv_pat[k], 16'h3C00, 16'hBC00);
            if (av_pat[k] && bv_pat[k]) begin
                dual++;
                exp_q.push_back({3'b000, 16'h4000});
            end
        end
        @(negedge aclk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (6) @(negedge aclk);
        check("mixed_valid_count", 19'(out_cnt - base), 19'(dual));

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            drive(1'b1, 1'b1, 16'h3C00, 16'hBC00);
            exp_q.push_back({3'b000, 16'h4000});
        end
        @(negedge aclk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge aclk);
        check("pre_reset_tvalid", {18'd0, r_tvalid}, 19'd1);
        #2 aresetn = 1'b0;
        #1;
        check("midreset_tvalid", {18'd0, r_tvalid}, 19'd0);
        check("midreset_tdata", {3'd0, r_tdata}, 19'd0);
        check("midreset_tuser", {16'd0, r_tuser}, 19'd0);
        exp_q.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            check($sformatf("post_reset_tvalid_k%0d", k), {18'd0, r_tvalid}, 19'd0);
        end

        check("queue_drained", 19'(exp_q.size()), 19'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
